// File: rtl/fir_output_quantizer.sv
// rtl/fir_output_quantizer.sv - FIR output round/shift/saturate stage with small output FIFO and overflow flag.
// Optional saturation counter enabled by defining FIR_OUT_SAT_CNT_EN.
module fir_output_quantizer #(
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic signed [ACC_W-1:0]            acc_in,
  input  logic                               acc_valid,
  output logic signed [OUT_W-1:0]            m_data,
  output logic                               m_sat,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               ovf,
  input  logic                               ovf_clr
`ifdef FIR_OUT_SAT_CNT_EN
  ,
  output logic [15:0]                        sat_count
`endif
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND  = (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(1 << (OUT_W-1)));

  // One guard bit so the rounding add cannot wrap.
  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_t;
  logic signed [OUT_W-1:0] w_q;
  logic                    w_q_sat;

  always_comb begin
    w_ext   = {acc_in[ACC_W-1], acc_in};
    w_rnd   = w_ext + RND;
    w_t     = w_rnd >>> SHIFT;
    w_q     = w_t[OUT_W-1:0];
    w_q_sat = 1'b0;
    if (w_t > MAXV) begin
      w_q     = MAXV[OUT_W-1:0];
      w_q_sat = 1'b1;
    end else if (w_t < MINV) begin
      w_q     = MINV[OUT_W-1:0];
      w_q_sat = 1'b1;
    end
  end

  logic signed [OUT_W-1:0] r_q_data;
  logic                    r_q_sat;
  logic                    r_q_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_data  <= '0;
      r_q_sat   <= 1'b0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_data  <= w_q;
      r_q_sat   <= w_q_sat;
      r_q_valid <= acc_valid;
    end
  end

  logic [OUT_W:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic signed [OUT_W-1:0] r_m_data;
  logic                 r_m_sat;
  logic                 r_ovf;

  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [PTR_W-1:0]     w_rd_next;
  logic [LVL_W-1:0]     w_lvl_next;
  logic [OUT_W:0]       w_head_next;

  always_comb begin
    w_full     = (r_level == LVL_W'(FIFO_DEPTH));
    w_pop      = (r_level != '0) && m_ready;
    w_push     = r_q_valid && (!w_full || w_pop);
    w_drop     = r_q_valid && w_full && !w_pop;
    w_rd_next  = r_rd_ptr + PTR_W'(w_pop);
    w_lvl_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    // The next head may be the entry being written this very cycle.
    if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_next = {r_q_sat, r_q_data};
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_q_sat, r_q_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_m_data <= '0;
      r_m_sat  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr <= w_rd_next;
      r_level  <= w_lvl_next;
      if (w_lvl_next != '0) begin
        r_m_data <= w_head_next[OUT_W-1:0];
        r_m_sat  <= w_head_next[OUT_W];
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef FIR_OUT_SAT_CNT_EN
  logic [15:0] r_sat_cnt;

  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      r_sat_cnt <= '0;
    end else if (r_q_valid && r_q_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_count = r_sat_cnt;
`endif

  assign m_data     = r_m_data;
  assign m_sat      = r_m_sat;
  assign m_valid    = (r_level != '0);
  assign fifo_level = r_level;
  assign ovf        = r_ovf;

endmodule
